hdlc_rx_protocol_monitor: RTL and testbench

- Synthesizable, parametrised protocol checker for the HDLC receive path. It watches the serial Rx line and the Rx controller status strobes.
- It flags three kinds of violation, each as a one-cycle pulse, and counts each kind in its own saturating counter:
  - flag detection that is late or missing;
  - an abort signal that is missing after an abort is detected;
  - idle-pattern violations while the link is disabled.
- Sits beside the Rx controller in the HDLC top level. Counters are readable by the register block, and ErrAny feeds the status/interrupt logic.

---
 rtl/hdlc_rx_protocol_monitor.sv | 113 +++++++++++
 tb/tb_hdlc_rx_protocol_monitor.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdlc_rx_protocol_monitor.sv
// Protocol checker for the HDLC receive path: flags late/missing flag detection,
// missing abort reporting and idle-pattern violations, with saturating error counters.
module hdlc_rx_protocol_monitor #(
  parameter int FLAG_LAT  = 2,
  parameter int ABORT_LAT = 1,
  parameter int IDLE_BITS = 8,
  parameter int CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             MonEn,
  input  logic             ClrCnt,
  input  logic             Rx,
  input  logic             RxEN,
  input  logic             TxEN,
  input  logic             Rx_FlagDetect,
  input  logic             Rx_ValidFrame,
  input  logic             Rx_AbortDetect,
  input  logic             Rx_AbortSignal,
  output logic             FlagErr,
  output logic             AbortErr,
  output logic             IdleErr,
  output logic [CNT_W-1:0] FlagErrCnt,
  output logic [CNT_W-1:0] AbortErrCnt,
  output logic [CNT_W-1:0] IdleErrCnt,
  output logic             ErrAny
);

  localparam int               IDLE_W   = $clog2(IDLE_BITS + 1);
  localparam logic [7:0]       FLAG_PAT = 8'h7E;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [7:0]           r_hist;
  logic [FLAG_LAT-1:0]  r_flag_pipe;
  logic [ABORT_LAT-1:0] r_abort_pipe;
  logic [IDLE_W-1:0]    r_idle_cnt;

  logic [7:0] w_hist;
  logic       w_flag_launch;
  logic       w_abort_launch;
  logic       w_idle_load;
  logic       w_flag_err;
  logic       w_abort_err;
  logic       w_idle_err;
  logic       w_any_pulse;

  // History includes the current Rx bit so a match lines up with the closing 0.
  assign w_hist         = {r_hist[6:0], Rx};
  assign w_flag_launch  = MonEn && (w_hist == FLAG_PAT);
  assign w_abort_launch = MonEn && Rx_AbortDetect && Rx_ValidFrame;
  assign w_idle_load    = MonEn && !TxEN && !RxEN;

  assign w_flag_err  = r_flag_pipe[FLAG_LAT-1] && !Rx_FlagDetect;
  assign w_abort_err = r_abort_pipe[ABORT_LAT-1] && !Rx_AbortSignal;
  assign w_idle_err  = MonEn && !Rx && (w_idle_load || (r_idle_cnt != '0));
  assign w_any_pulse = FlagErr || AbortErr || IdleErr;

  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] cnt,
                                                input logic pulse,
                                                input logic clr);
    logic [CNT_W-1:0] res;
    res = cnt;
    if (clr) begin
      res = CNT_W'(pulse);
    end else if (pulse && (cnt != CNT_MAX)) begin
      res = cnt + 1'b1;
    end
    return res;
  endfunction

  // Pending checks advance one stage per cycle; the last stage is the check cycle.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_hist       <= 8'hFF;
      r_flag_pipe  <= '0;
      r_abort_pipe <= '0;
      r_idle_cnt   <= '0;
      FlagErr      <= 1'b0;
      AbortErr     <= 1'b0;
      IdleErr      <= 1'b0;
    end else begin
      r_hist       <= w_hist;
      r_flag_pipe  <= (r_flag_pipe << 1) | FLAG_LAT'(w_flag_launch);
      r_abort_pipe <= (r_abort_pipe << 1) | ABORT_LAT'(w_abort_launch);
      if (!MonEn) begin
        r_idle_cnt <= '0;
      end else if (w_idle_load) begin
        r_idle_cnt <= IDLE_W'(IDLE_BITS);
      end else if (r_idle_cnt != '0) begin
        r_idle_cnt <= r_idle_cnt - 1'b1;
      end
      FlagErr  <= w_flag_err;
      AbortErr <= w_abort_err;
      IdleErr  <= w_idle_err;
    end
  end

  // A pulse coinciding with ClrCnt survives the clear.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      FlagErrCnt  <= '0;
      AbortErrCnt <= '0;
      IdleErrCnt  <= '0;
      ErrAny      <= 1'b0;
    end else begin
      FlagErrCnt  <= next_cnt(FlagErrCnt, FlagErr, ClrCnt);
      AbortErrCnt <= next_cnt(AbortErrCnt, AbortErr, ClrCnt);
      IdleErrCnt  <= next_cnt(IdleErrCnt, IdleErr, ClrCnt);
      ErrAny      <= ClrCnt ? w_any_pulse : (ErrAny || w_any_pulse);
    end
  end

endmodule

// File: tb/tb_hdlc_rx_protocol_monitor.sv
// Bench for hdlc_rx_protocol_monitor: two differently parametrised instances share
// stimulus; a cycle-history reference model feeds per-instance expected queues.
module tb_hdlc_rx_protocol_monitor;

  localparam int NMAX = 4096;
  localparam int A_FL = 2, A_AL = 1, A_IB = 8, A_CW = 4;
  localparam int B_FL = 4, B_AL = 3, B_IB = 5, B_CW = 16;
  localparam int W = 52;

  // clock / reset
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic Rst = 1'b0;
  logic MonEn, ClrCnt, Rx, RxEN, TxEN;
  logic Rx_FlagDetect, Rx_ValidFrame, Rx_AbortDetect, Rx_AbortSignal;

  logic            a_ferr, a_aerr, a_ierr, a_any;
  logic [A_CW-1:0] a_fcnt, a_acnt, a_icnt;
  logic            b_ferr, b_aerr, b_ierr, b_any;
  logic [B_CW-1:0] b_fcnt, b_acnt, b_icnt;

  hdlc_rx_protocol_monitor #(.FLAG_LAT(A_FL), .ABORT_LAT(A_AL), .IDLE_BITS(A_IB), .CNT_W(A_CW)) u_dut_a (
    .Clk(Clk), .Rst(Rst), .MonEn(MonEn), .ClrCnt(ClrCnt), .Rx(Rx), .RxEN(RxEN), .TxEN(TxEN),
    .Rx_FlagDetect(Rx_FlagDetect), .Rx_ValidFrame(Rx_ValidFrame),
    .Rx_AbortDetect(Rx_AbortDetect), .Rx_AbortSignal(Rx_AbortSignal),
    .FlagErr(a_ferr), .AbortErr(a_aerr), .IdleErr(a_ierr),
    .FlagErrCnt(a_fcnt), .AbortErrCnt(a_acnt), .IdleErrCnt(a_icnt), .ErrAny(a_any));

  hdlc_rx_protocol_monitor #(.FLAG_LAT(B_FL), .ABORT_LAT(B_AL), .IDLE_BITS(B_IB), .CNT_W(B_CW)) u_dut_b (
    .Clk(Clk), .Rst(Rst), .MonEn(MonEn), .ClrCnt(ClrCnt), .Rx(Rx), .RxEN(RxEN), .TxEN(TxEN),
    .Rx_FlagDetect(Rx_FlagDetect), .Rx_ValidFrame(Rx_ValidFrame),
    .Rx_AbortDetect(Rx_AbortDetect), .Rx_AbortSignal(Rx_AbortSignal),
    .FlagErr(b_ferr), .AbortErr(b_aerr), .IdleErr(b_ierr),
    .FlagErrCnt(b_fcnt), .AbortErrCnt(b_acnt), .IdleErrCnt(b_icnt), .ErrAny(b_any));

  // input history, one entry per clock cycle
  bit h_rst[NMAX], h_mon[NMAX], h_clr[NMAX], h_rx[NMAX], h_re[NMAX], h_te[NMAX];
  bit h_fd[NMAX], h_vf[NMAX], h_ad[NMAX], h_as[NMAX];
  int cyc = 0;

  int m_cnt[2][3];
  bit m_pulse[2][3];
  bit m_any[2];

  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic bit any_rst(int lo, int hi);
    for (int j = lo; j <= hi; j++) begin
      if (j < 0 || h_rst[j]) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Rx as the history register sees it: everything up to a reset reads as 1.
  function automatic bit eff_rx(int j, int t);
    if (j < 0 || any_rst(j, t)) return 1'b1;
    return h_rx[j];
  endfunction

  function automatic bit flag_match(int t);
    if (t < 0 || h_rst[t] || !h_mon[t]) return 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (eff_rx(t - 7 + k, t) != ((k == 0 || k == 7) ? 1'b0 : 1'b1)) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit flag_err_at(int c, int lat);
    int t = c - lat;
    if (t < 0 || any_rst(t, c)) return 1'b0;
    return flag_match(t) && !h_fd[c];
  endfunction

  function automatic bit abort_err_at(int c, int lat);
    int t = c - lat;
    if (t < 0 || any_rst(t, c)) return 1'b0;
    return h_mon[t] && h_ad[t] && h_vf[t] && !h_as[c];
  endfunction

  function automatic bit is_load(int j);
    return h_mon[j] && !h_te[j] && !h_re[j];
  endfunction

  // Rx low in the load cycle or within ib cycles after the latest load, MonEn held.
  function automatic bit idle_err_at(int c, int ib);
    if (h_rst[c] || !h_mon[c] || h_rx[c]) return 1'b0;
    if (is_load(c)) return 1'b1;
    for (int j = c - 1; j >= c - ib && j >= 0; j--) begin
      if (h_rst[j]) return 1'b0;
      if (is_load(j)) return 1'b1;
      if (!h_mon[j]) return 1'b0;
    end
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] model_step(int d, int c, int fl, int al, int ib, int cw);
    bit np[3];
    bit prev_any;
    int mx = (1 << cw) - 1;
    prev_any = m_pulse[d][0] | m_pulse[d][1] | m_pulse[d][2];
    if (h_rst[c]) begin
      for (int k = 0; k < 3; k++) begin
        np[k] = 1'b0;
        m_cnt[d][k] = 0;
      end
      m_any[d] = 1'b0;
    end else begin
      np[0] = flag_err_at(c, fl);
      np[1] = abort_err_at(c, al);
      np[2] = idle_err_at(c, ib);
      for (int k = 0; k < 3; k++) begin
        if (h_clr[c]) m_cnt[d][k] = m_pulse[d][k] ? 1 : 0;
        else if (m_pulse[d][k] && m_cnt[d][k] < mx) m_cnt[d][k] = m_cnt[d][k] + 1;
      end
      m_any[d] = h_clr[c] ? prev_any : (m_any[d] | prev_any);
    end
    for (int k = 0; k < 3; k++) m_pulse[d][k] = np[k];
    return {np[0], np[1], np[2], m_any[d], 16'(m_cnt[d][0]), 16'(m_cnt[d][1]), 16'(m_cnt[d][2])};
  endfunction

  // driver tasks: inputs are set at the falling edge, then step() records them
  task automatic step();
    h_rst[cyc] = !Rst;   h_mon[cyc] = MonEn;  h_clr[cyc] = ClrCnt;
    h_rx[cyc]  = Rx;     h_re[cyc]  = RxEN;   h_te[cyc]  = TxEN;
    h_fd[cyc]  = Rx_FlagDetect;  h_vf[cyc] = Rx_ValidFrame;
    h_ad[cyc]  = Rx_AbortDetect; h_as[cyc] = Rx_AbortSignal;
    exp_q_a.push_back(model_step(0, cyc, A_FL, A_AL, A_IB, A_CW));
    exp_q_b.push_back(model_step(1, cyc, B_FL, B_AL, B_IB, B_CW));
    cyc++;
    @(negedge Clk);
  endtask

  task automatic quiet();
    MonEn = 1'b1; ClrCnt = 1'b0; Rx = 1'b1; RxEN = 1'b1; TxEN = 1'b1;
    Rx_FlagDetect = 1'b0; Rx_ValidFrame = 1'b0; Rx_AbortDetect = 1'b0; Rx_AbortSignal = 1'b0;
  endtask

  task automatic idle_steps(input int n);
    quiet();
    for (int i = 0; i < n; i++) step();
  endtask

  // Rx 0,1,1,1,1,1,1,0 then FlagDetect only fd_after cycles after the closing 0 (0: never).
  task automatic send_flag(input int fd_after);
    for (int i = 0; i < 8; i++) begin
      Rx = (i == 0 || i == 7) ? 1'b0 : 1'b1;
      step();
    end
    for (int k = 1; k <= 6; k++) begin
      Rx = 1'b1;
      Rx_FlagDetect = (k == fd_after);
      step();
    end
    Rx_FlagDetect = 1'b0;
  endtask

  task automatic send_abort(input bit vf, input bit sig);
    Rx_ValidFrame = vf; Rx_AbortDetect = 1'b1; step();
    Rx_AbortDetect = 1'b0; Rx_AbortSignal = sig; step();
    Rx_AbortSignal = 1'b0; Rx_ValidFrame = 1'b0;
    idle_steps(5);
  endtask

  task automatic idle_window(input int low_at);
    TxEN = 1'b0; RxEN = 1'b0; step();
    TxEN = 1'b1; RxEN = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      Rx = (k == low_at) ? 1'b0 : 1'b1;
      step();
    end
    Rx = 1'b1;
  endtask

  // scoreboard monitor: one expected vector per cycle, checked after the rising edge
  initial begin
    logic [W-1:0] e, got;
    int ca = 0, cb = 0;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q_a.size() > 0) begin
        e = exp_q_a.pop_front();
        got = {a_ferr, a_aerr, a_ierr, a_any, 16'(a_fcnt), 16'(a_acnt), 16'(a_icnt)};
        n_cmp++;
        if (got !== e) begin
          n_bad++;
          $display("FAIL dut_a cycle %0d: got %h expected %h (ferr,aerr,ierr,any,fcnt,acnt,icnt)", ca, got, e);
        end
        ca++;
      end
      if (exp_q_b.size() > 0) begin
        e = exp_q_b.pop_front();
        got = {b_ferr, b_aerr, b_ierr, b_any, 16'(b_fcnt), 16'(b_acnt), 16'(b_icnt)};
        n_cmp++;
        if (got !== e) begin
          n_bad++;
          $display("FAIL dut_b cycle %0d: got %h expected %h (ferr,aerr,ierr,any,fcnt,acnt,icnt)", cb, got, e);
        end
        cb++;
      end
    end
  end

  // main stimulus
  initial begin
    quiet();
    Rst = 1'b0;
    @(negedge Clk);
    for (int i = 0; i < 3; i++) step();
    Rst = 1'b1;
    idle_steps(4);

    send_flag(2);            // detected on time for instance A
    idle_steps(4);
    send_flag(0);            // missing detection
    idle_steps(4);

    send_abort(1'b1, 1'b0);  // abort not reported
    send_abort(1'b1, 1'b1);  // abort reported
    send_abort(1'b0, 1'b0);  // outside a frame: no check

    idle_window(5);
    idle_steps(3);
    idle_window(9);
    idle_steps(3);

    // back-to-back overlapping flags drive counter A into saturation
    Rx = 1'b0; step();
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < 6; i++) begin Rx = 1'b1; step(); end
      Rx = 1'b0; step();
    end
    idle_steps(8);

    // clear in the very cycle the abort error pulse is out
    Rx_ValidFrame = 1'b1; Rx_AbortDetect = 1'b1; step();
    Rx_AbortDetect = 1'b0; Rx_AbortSignal = 1'b0; step();
    ClrCnt = 1'b1; step();
    idle_steps(6);

    // reset in the middle of pending flag and abort checks
    for (int i = 0; i < 8; i++) begin
      Rx = (i == 0 || i == 7) ? 1'b0 : 1'b1;
      Rx_ValidFrame = (i == 7); Rx_AbortDetect = (i == 7);
      step();
    end
    quiet(); step(); step();
    Rst = 1'b0; step();
    Rst = 1'b1;
    idle_steps(8);

    // monitor disabled during a flag, then disabled just after a launch
    MonEn = 1'b0;
    send_flag(0);
    idle_steps(3);
    for (int i = 0; i < 8; i++) begin
      Rx = (i == 0 || i == 7) ? 1'b0 : 1'b1;
      step();
    end
    Rx = 1'b1; MonEn = 1'b0;
    for (int i = 0; i < 6; i++) step();
    idle_steps(4);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      Rst            = ($urandom_range(0, 299) != 0);
      MonEn          = ($urandom_range(0, 19) != 0);
      ClrCnt         = ($urandom_range(0, 49) == 0);
      Rx             = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) begin
        TxEN = 1'b0; RxEN = 1'b0;
      end else begin
        TxEN = ($urandom_range(0, 9) != 0); RxEN = ($urandom_range(0, 9) != 0);
      end
      Rx_FlagDetect  = 1'($urandom_range(0, 1));
      Rx_ValidFrame  = 1'($urandom_range(0, 1));
      Rx_AbortDetect = ($urandom_range(0, 7) == 0);
      Rx_AbortSignal = 1'($urandom_range(0, 1));
      step();
    end
    Rst = 1'b1;
    idle_steps(10);

    repeat (3) @(posedge Clk);
    #3;
    n_cmp++;
    if (exp_q_a.size() != 0 || exp_q_b.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d entries left, required 0/0", exp_q_a.size(), exp_q_b.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
